// File: rtl/fx2_slave_fifo_emu.sv
// fx2_slave_fifo_emu: emulates the USB controller's slave-FIFO end (EP2 in, EP6 out) for loopback benches.
// Ports: IFCLK/RESET_N (async active-low); master side FIFOADR, SLOE, SLRD, SLWR, PKTEND, FIFO_DATA_IN,
// FIFO_DATA_OUT, FIFO_DATA_OE, FLAGA/B/C; host side host_din/host_wr_en/host_full (EP2 push),
// host_dout/host_rd_en/host_empty (EP6 committed drain); status zlp_count, err (sticky).
module fx2_slave_fifo_emu #(
  parameter int EP2_DEPTH_LOG2 = 11,
  parameter int EP6_DEPTH_LOG2 = 11,
  parameter int PKT_WORDS      = 256
) (
  input  logic        IFCLK,
  input  logic        RESET_N,
  input  logic [1:0]  FIFOADR,
  input  logic        SLOE,
  input  logic        SLRD,
  input  logic        SLWR,
  input  logic        PKTEND,
  input  logic [15:0] FIFO_DATA_IN,
  output logic [15:0] FIFO_DATA_OUT,
  output logic        FIFO_DATA_OE,
  output logic        FLAGA,
  output logic        FLAGB,
  output logic        FLAGC,
  input  logic [15:0] host_din,
  input  logic        host_wr_en,
  output logic        host_full,
  output logic [15:0] host_dout,
  input  logic        host_rd_en,
  output logic        host_empty,
  output logic [7:0]  zlp_count,
  output logic [3:0]  err
);
  localparam int A2 = EP2_DEPTH_LOG2;
  localparam int A6 = EP6_DEPTH_LOG2;
  localparam logic [A2:0] FULL2 = (A2+1)'(2**A2);
  localparam logic [A6:0] FULL6 = (A6+1)'(2**A6);
  logic [15:0] mem2 [2**A2];
  logic [15:0] mem6 [2**A6];
  logic [A2:0] wp2, rp2, wp2_n, rp2_n, occ2_n;
  logic [A6:0] wp6, cp6, rp6, wp6_n, cp6_n, rp6_n, unc_n, occ6_n;
  logic rd, wr, pe, ep2_sel, ep6_sel, bad, do_rd, do_wr;
  logic empty2, full2, full6, pop2, push2, push6, pop6;
  logic auto_commit, pe_ep6, commit, zlp_inc, flagb_n, flagc_n;
  assign rd      = !SLRD;
  assign wr      = !SLWR;
  assign pe      = !PKTEND;
  assign ep2_sel = FIFOADR == 2'b00;
  assign ep6_sel = FIFOADR == 2'b10;
  assign bad     = FIFOADR[0] && (rd || wr || pe);
  // simultaneous read and write strobes cancel each other
  assign do_rd   = rd && !wr && ep2_sel;
  assign do_wr   = wr && !rd && ep6_sel;
  assign empty2  = wp2 == rp2;
  assign full2   = (wp2 - rp2) == FULL2;
  // EP6 capacity counts uncommitted words too, so fullness is measured against the host read pointer
  assign full6   = (wp6 - rp6) == FULL6;
  assign pop2    = do_rd && !empty2;
  assign push2   = host_wr_en && !full2;
  assign push6   = do_wr && !full6;
  assign pop6    = host_rd_en && !host_empty;
  assign wp2_n   = wp2 + (A2+1)'(push2);
  assign rp2_n   = rp2 + (A2+1)'(pop2);
  assign wp6_n   = wp6 + (A6+1)'(push6);
  assign rp6_n   = rp6 + (A6+1)'(pop6);
  assign unc_n   = wp6_n - cp6;
  assign auto_commit = push6 && 32'(unc_n) == PKT_WORDS;
  assign pe_ep6  = pe && ep6_sel;
  // an auto-commit leaves unc_n nonzero, so PKTEND on that edge never counts as a ZLP
  assign commit  = auto_commit || (pe_ep6 && |unc_n);
  assign zlp_inc = pe_ep6 && !(|unc_n);
  assign cp6_n   = commit ? wp6_n : cp6;
  assign occ2_n  = wp2_n - rp2_n;
  assign occ6_n  = wp6_n - rp6_n;
  assign flagb_n = ep2_sel ? occ2_n != FULL2 : ep6_sel ? occ6_n != FULL6 : 1'b1;
  assign flagc_n = ep2_sel ? |occ2_n : ep6_sel ? |occ6_n : 1'b0;
  assign FIFO_DATA_OUT = empty2 ? 16'h0 : mem2[rp2[A2-1:0]];
  assign FIFO_DATA_OE  = !SLOE && ep2_sel;
  assign host_full     = full2;
  assign host_empty    = rp6 == cp6;
  assign host_dout     = mem6[rp6[A6-1:0]];
  assign FLAGA         = !host_empty;
  always_ff @(posedge IFCLK or negedge RESET_N)
    if (!RESET_N) begin
      wp2       <= '0;
      rp2       <= '0;
      wp6       <= '0;
      cp6       <= '0;
      rp6       <= '0;
      zlp_count <= '0;
      err       <= '0;
      FLAGB     <= 1'b1;
      FLAGC     <= 1'b0;
    end else begin
      wp2       <= wp2_n;
      rp2       <= rp2_n;
      wp6       <= wp6_n;
      cp6       <= cp6_n;
      rp6       <= rp6_n;
      zlp_count <= zlp_count + 8'(zlp_inc);
      err       <= err | {bad, rd && wr, do_wr && full6, do_rd && empty2};
      FLAGB     <= flagb_n;
      FLAGC     <= flagc_n;
    end
  always_ff @(posedge IFCLK) begin
    if (push2) mem2[wp2[A2-1:0]] <= host_din;
    if (push6) mem6[wp6[A6-1:0]] <= FIFO_DATA_IN;
  end
endmodule

// File: doc/fx2_slave_fifo_emu.md
# fx2_slave_fifo_emu

Synthesizable emulator of the USB controller's slave-FIFO end of the high-speed I/O interface. It responds to the FPGA-side FIFO master signals: FIFOADR, SLOE, SLRD, SLWR and PKTEND. It returns FLAGA/FLAGB/FLAGC and data exactly as the bitstream's slave-FIFO master expects. A host-side word port feeds the input endpoint (EP2) and drains committed packets from the output endpoint (EP6). It sits opposite the high-speed I/O master in loopback test fabrics and simulation harnesses, replacing the real USB controller.

## Interface
Parameters:
- EP2_DEPTH_LOG2, 11, log2 of EP2 depth in 16-bit words (FPGA reads from EP2).
- EP6_DEPTH_LOG2, 11, log2 of EP6 depth in 16-bit words (FPGA writes to EP6).
- PKT_WORDS, 256, EP6 auto-commit packet size in words (512 bytes).

Ports (one clock; reset is asynchronous and active-low):
- IFCLK  in  1  interface clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- FIFOADR  in  2  endpoint select: 00 = EP2, 10 = EP6; 01 and 11 are invalid.
- SLOE  in  1  active-low output enable for FIFO_DATA_OUT.
- SLRD  in  1  active-low read strobe.
- SLWR  in  1  active-low write strobe.
- PKTEND  in  1  active-low packet end.
- FIFO_DATA_IN  in  16  data written by the master.
- FIFO_DATA_OUT  out  16  head word of EP2.
- FIFO_DATA_OE  out  1  drive enable for FIFO_DATA_OUT.
- FLAGA  out  1  high when at least one committed EP6 packet awaits the host.
- FLAGB  out  1  active-low FULL of the addressed endpoint.
- FLAGC  out  1  active-low EMPTY of the addressed endpoint.
- host_din  in  16  word pushed into EP2.
- host_wr_en  in  1  push strobe.
- host_full  out  1  EP2 full.
- host_dout  out  16  EP6 head word.
- host_rd_en  in  1  pop strobe.
- host_empty  out  1  no committed EP6 words available.
- zlp_count  out  8  count of zero-length packets, wraps at 255.
- err  out  4  sticky errors: [0] underrun, [1] overrun, [2] SLRD/SLWR conflict, [3] bad address.

## Operation
- **EP2:** circular buffer with pointers one bit wider than the address.
  - Host push is accepted only when EP2 is not full.
  - FIFO_DATA_OUT always shows the current head word; it is 0 when EP2 is empty.
  - FIFO_DATA_OE = !SLOE && FIFOADR==00 (combinational).
- **EP6:** write pointer wp, commit pointer cp, read pointer rp.
  - Host can see only the words between rp and cp; host_empty = (rp==cp).
  - uncommitted = wp - cp.
- **Read:** on an edge with SLRD=0 and FIFOADR=00:
  - EP2 not empty: pop one word.
  - EP2 empty: no pop; set err[0].
- **Write:** on an edge with SLWR=0 and FIFOADR=10:
  - EP6 not full: store FIFO_DATA_IN.
  - EP6 full: drop the word; set err[1].
- **Auto-commit:** when a write makes uncommitted reach PKT_WORDS, cp jumps to the new wp in the same edge.
- **PKTEND=0 with FIFOADR=10:**
  - If uncommitted is nonzero after any same-edge write: cp moves to the new wp, so the same-edge word is included.
  - Otherwise: zlp_count increments.
  - PKTEND asserted on the same edge as an auto-commit does not produce a ZLP.
- **SLRD=0 and SLWR=0 on the same edge:** neither acts; set err[2].
- **Bad address:** a strobe (SLRD, SLWR or PKTEND) with FIFOADR of 01 or 11 is ignored and sets err[3].
- **Host side:** host_rd_en with host_empty high is ignored. Host and master operations on the same endpoint in the same edge both take effect.
- **FLAGA:** high when (cp - rp) ≥ PKT_WORDS, or when an uncommitted-free short packet is pending; it is simply !host_empty.
- **Reset:** clears all pointers, zlp_count and err.
  - Flags go to FLAGB=1 and FLAGC=0; FLAGA=0.
  - host_full=0, host_empty=1.
  - FIFO_DATA_OUT=0.
  - Reset mid-packet discards all EP6 data, committed or not.

## Timing
- FLAGB and FLAGC are registered. They reflect FIFOADR and the post-edge occupancy sampled on edge N, and are valid after edge N.
  - One-cycle latency after an address change or a transfer.
  - The master must tolerate one extra strobe; that strobe is caught as an underrun or overrun, never as corruption.
- FIFO_DATA_OUT updates on the same edge as the pop (zero wait states).
- host_dout is the combinational head of EP6. host_full and host_empty are combinational from the pointers.
- Throughput: one master word and one host word per cycle per endpoint.

## Test plan
- **EP2 stream:** host pushes 0x0001..0x0010, then the master reads with SLRD=0 for 16 cycles at FIFOADR=00.
  - Words arrive in order.
  - FLAGC falls to 0 one cycle after the last pop.
  - A 17th SLRD sets err=0001.
- **EP6 auto-commit:** master writes 256 words.
  - host_empty stays 1 through word 255 and drops to 0 right after word 256.
  - FLAGA=1.
  - The host reads back all 256 words intact.
- **PKTEND with data:** write 3 words, then write a 4th word with PKTEND=0 on the same edge.
  - Exactly 4 words become visible to the host.
  - zlp_count stays 0.
- **Zero-length packet:** PKTEND=0 with nothing uncommitted.
  - zlp_count goes to 1.
  - host_empty stays 1.
- **Overflow with EP6_DEPTH_LOG2=4:** write 17 words with the host idle.
  - The 17th word is dropped and err[1] is set.
  - FLAGB=0 one cycle after the 16th word.
- **Conflict and reset:** SLRD=0 and SLWR=0 together give err[2] with no pointer movement. RESET_N low mid-packet clears every output to its reset value asynchronously.
